logic_l4_sched: RTL
===================

# logic_l4_sched

Round-robin scheduler that shares one accumulate-and-scramble datapath (`logic_l4`) between `PAR_REQ` requesters. It grants one requester at a time, clears the datapath, streams that requester's burst into it, waits for the datapath to settle, then returns the captured result tagged with the requester id. It sits between the requester fabric and a single `logic_l4` instance wired to its `dp` ports.

## Interface
- `PAR_DATA_BITS`, 8: datapath word width; even, ≥2.
- `PAR_REQ`, 4: number of requesters; ≥2.
- `PAR_DP_LAT`, 2: cycles from the last data word on `ovG_dp_data` to a valid `ivG_dp_data`; ≥1.
- `PAR_MAX_BEATS`, 16: maximum words per burst; longer bursts are truncated.
- `ib_clk`, input, 1: clock.
- `ib_rst_n`, input, 1: reset, asynchronous, active-low.
- `iv_req_valid`, input, `PAR_REQ`: per-requester word valid.
- `ivG_req_data`, input, `PAR_REQ*PAR_DATA_BITS`: requester *i* data is in slice `[i*W +: W]`.
- `iv_req_last`, input, `PAR_REQ`: marks the last word of a burst.
- `ov_req_ready`, output, `PAR_REQ`: one-hot or zero; a word transfers when valid and ready are both high.
- `ob_dp_clr`, output, 1: synchronous clear to the datapath (its `ib_rst`).
- `ovG_dp_data`, output, `PAR_DATA_BITS`: datapath input word.
- `ivG_dp_data`, input, `PAR_DATA_BITS`: datapath output.
- `ob_res_valid`, output, 1: result available.
- `ib_res_ready`, input, 1: result consumer ready.
- `ovG_res_data`, output, `PAR_DATA_BITS`: captured result.
- `ov_res_id`, output, `$clog2(PAR_REQ)`: id of the granted requester.
- `ob_res_trunc`, output, 1: the burst was cut at `PAR_MAX_BEATS`.

## Operation
- FSM states: IDLE, CLEAR, ACCUM, WAIT, RESULT.
- **IDLE**
  - If any `iv_req_valid` is high, grant the first valid requester searching upward (with wrap) from `rr_ptr+1`.
  - Latch the grant id and go to CLEAR. Otherwise stay in IDLE.
- **CLEAR**
  - `ob_dp_clr=1` and `ovG_dp_data=0` for exactly one cycle.
  - Reset the beat counter, clear the trunc flag, go to ACCUM.
- **ACCUM**
  - `ov_req_ready[grant]=1`.
  - On a transfer: `ovG_dp_data` = the granted slice, and the beat counter increments.
  - On a non-transfer cycle: `ovG_dp_data=0`, because the datapath accumulates every cycle.
  - On `last` with a transfer, go to WAIT.
  - If a transfer takes the beat count to `PAR_MAX_BEATS` without `last`, set trunc and go to WAIT. The requester's remaining words are not consumed by this grant.
- **WAIT**
  - `ovG_dp_data=0`; count `PAR_DP_LAT` cycles.
  - On the final count, register `ivG_dp_data` into `ovG_res_data` and go to RESULT.
- **RESULT**
  - `ob_res_valid=1` with data, id and trunc stable until `ib_res_ready`.
  - On the handshake: `rr_ptr` = grant id, go to IDLE.
- `ovG_dp_data` is combinational from the state and the granted slice. All other outputs are registered.
- Arithmetic (sum wrap modulo 2^`PAR_DATA_BITS`) lives in the datapath. This block only sequences it.

## Timing
- Reset values:
  - All outputs 0; FSM in IDLE.
  - `rr_ptr = PAR_REQ-1`, so requester 0 wins the first arbitration.
- Latency:
  - Request valid in IDLE, then CLEAR on the next cycle, then the first word can transfer one cycle after CLEAR.
  - The result is valid `PAR_DP_LAT+1` cycles after the last-word transfer.
- A result handshake always returns to IDLE. Arbitration happens in the following cycle (one bubble between grants).
- A requester dropping valid mid-burst is legal; the burst waits in ACCUM indefinitely.
- Requests arriving outside IDLE are held by the requester (valid/ready rules) and never lost.
- Reset asserted mid-burst: immediate return to reset values. The burst is abandoned with no result and no ready pulses.
- A single-beat burst (`last` on the first word) is legal.

## Structure
- `logic_l4_sched_pkg` holds:
  - the FSM state enum `t_sched_state`;
  - the function `f_rr_pick(valid, ptr)` returning the next grant id.
- One sub-module, `rr_arbiter`: combinational round-robin pick from `PAR_REQ` valids and a pointer, producing a one-hot grant and an id. The pointer register stays in the top.
- Beat counter width: `$clog2(PAR_MAX_BEATS+1)`. WAIT counter width: `$clog2(PAR_DP_LAT+1)`.

## Test plan
Defaults apply; the bench connects a real `logic_l4`.
- **Basic burst.** Reset, then requester 2 sends 3,5,7 with `last` on 7.
  - `ob_dp_clr` pulses once.
  - `ovG_dp_data` sequence is 0,3,5,7,0,0.
  - Result id=2, trunc=0, data equal to `ivG_dp_data` 2 cycles after the 7.
- **Round-robin order.** Requesters 0 and 3 are both valid continuously with 1-beat bursts.
  - Grants alternate 0,3,0,3.
  - Adding requester 1 gives the order 0,1,3,0.
- **Gaps mid-burst.** Requester 1 sends 4, idles 3 cycles, then sends 4 with `last`.
  - `ovG_dp_data` is 0 on the gap cycles.
  - The result matches a gapless 4,4 run.
- **Truncation.** Requester 0 sends 20 words of value 1 with no early `last`.
  - Exactly 16 words are consumed, trunc=1.
  - The remaining 4 words are served in a later grant with trunc=0.
- **Result backpressure.** Hold `ib_res_ready=0` for 10 cycles.
  - Valid, data and id stay stable.
  - No `ov_req_ready` is asserted until the handshake plus one cycle.
- **Reset mid-operation.** Assert `ib_rst_n=0` during ACCUM after 2 beats.
  - All outputs go to 0 immediately.
  - After release, requester 0 is granted first and no stale result appears.

Source files
------------

// File: rtl/logic_l4_sched_pkg.sv
// Shared types and helpers for the logic_l4 round-robin scheduler.
package logic_l4_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACCUM,
    ST_WAIT,
    ST_RESULT
  } t_sched_state;

  // Returns the first set bit of valid searching upward from ptr+1 with
  // wrap at n. Returns 0 when nothing is valid; callers qualify with |valid.
  function automatic int f_rr_pick(input logic [31:0] valid, input int ptr, input int n = 32);
    int pick;
    logic hit;
    logic [4:0] idx;
    pick = 0;
    hit  = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      if (k <= n) begin
        idx = 5'((ptr + k) % n);
        if (!hit && valid[idx]) begin
          pick = int'(idx);
          hit  = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/logic_l4_sched_rr_arbiter.sv
// Combinational round-robin pick: one-hot grant and id from valids and pointer.
module rr_arbiter #(
  parameter int PAR_REQ = 4,
  parameter int ID_W    = $clog2(PAR_REQ)
) (
  input  logic [PAR_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [PAR_REQ-1:0] grant,
  output logic [ID_W-1:0]    id,
  output logic               any
);
  import logic_l4_sched_pkg::*;

  logic [31:0] valid_ext;

  assign valid_ext = 32'(valid);
  assign any       = |valid;
  assign id        = ID_W'(f_rr_pick(valid_ext, int'(ptr), PAR_REQ));

  // One-hot decode of the picked id, gated so no grant shows when idle.
  for (genvar gi = 0; gi < PAR_REQ; gi++) begin : g_onehot
    assign grant[gi] = any && (id == ID_W'(gi));
  end

endmodule

// File: rtl/logic_l4_sched.sv
// Round-robin scheduler sharing one logic_l4 accumulate datapath between requesters.
module logic_l4_sched #(
  parameter int PAR_DATA_BITS = 8,
  parameter int PAR_REQ       = 4,
  parameter int PAR_DP_LAT    = 2,
  parameter int PAR_MAX_BEATS = 16
) (
  input  logic                               ib_clk,
  input  logic                               ib_rst_n,
  input  logic [PAR_REQ-1:0]                 iv_req_valid,
  input  logic [PAR_REQ*PAR_DATA_BITS-1:0]   ivG_req_data,
  input  logic [PAR_REQ-1:0]                 iv_req_last,
  output logic [PAR_REQ-1:0]                 ov_req_ready,
  output logic                               ob_dp_clr,
  output logic [PAR_DATA_BITS-1:0]           ovG_dp_data,
  input  logic [PAR_DATA_BITS-1:0]           ivG_dp_data,
  output logic                               ob_res_valid,
  input  logic                               ib_res_ready,
  output logic [PAR_DATA_BITS-1:0]           ovG_res_data,
  output logic [$clog2(PAR_REQ)-1:0]         ov_res_id,
  output logic                               ob_res_trunc
);
  import logic_l4_sched_pkg::*;

  localparam int ID_W   = $clog2(PAR_REQ);
  localparam int BEAT_W = $clog2(PAR_MAX_BEATS + 1);
  localparam int LAT_W  = $clog2(PAR_DP_LAT + 1);

  t_sched_state              state_reg, state_next;
  logic [ID_W-1:0]           rr_ptr_reg, grant_id_reg;
  logic [PAR_REQ-1:0]        grant_oh_reg, ready_reg;
  logic [BEAT_W-1:0]         beat_reg, beat_inc;
  logic [LAT_W-1:0]          wait_reg;
  logic                      trunc_reg, clr_reg, res_valid_reg;
  logic [PAR_DATA_BITS-1:0]  res_data_reg, grant_slice;

  logic [PAR_REQ-1:0]        arb_grant;
  logic [ID_W-1:0]           arb_id;
  logic                      arb_any;
  logic                      xfer, xfer_last, beat_full, wait_done;

  rr_arbiter #(.PAR_REQ(PAR_REQ), .ID_W(ID_W)) u_arb (
    .valid (iv_req_valid),
    .ptr   (rr_ptr_reg),
    .grant (arb_grant),
    .id    (arb_id),
    .any   (arb_any)
  );

  assign grant_slice = ivG_req_data[grant_id_reg*PAR_DATA_BITS +: PAR_DATA_BITS];
  assign xfer        = (state_reg == ST_ACCUM) && |(iv_req_valid & grant_oh_reg);
  assign xfer_last   = |(iv_req_last & grant_oh_reg);
  assign beat_inc    = beat_reg + BEAT_W'(1);
  assign beat_full   = (beat_inc == BEAT_W'(PAR_MAX_BEATS));
  assign wait_done   = (wait_reg == LAT_W'(PAR_DP_LAT - 1));

  // The datapath sums every cycle, so anything but a real transfer feeds zero.
  assign ovG_dp_data  = xfer ? grant_slice : '0;
  assign ov_req_ready = ready_reg;
  assign ob_dp_clr    = clr_reg;
  assign ob_res_valid = res_valid_reg;
  assign ovG_res_data = res_data_reg;
  assign ov_res_id    = grant_id_reg;
  assign ob_res_trunc = trunc_reg;

  // Next-state decode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (arb_any) state_next = ST_CLEAR;
      ST_CLEAR:  state_next = ST_ACCUM;
      ST_ACCUM:  if (xfer && (xfer_last || beat_full)) state_next = ST_WAIT;
      ST_WAIT:   if (wait_done) state_next = ST_RESULT;
      ST_RESULT: if (ib_res_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge ib_clk or negedge ib_rst_n) begin
    if (!ib_rst_n) state_reg <= ST_IDLE;
    else           state_reg <= state_next;
  end

  // Grant, counters, result capture and registered handshake outputs.
  always_ff @(posedge ib_clk or negedge ib_rst_n) begin
    if (!ib_rst_n) begin
      rr_ptr_reg    <= ID_W'(PAR_REQ - 1);
      grant_id_reg  <= '0;
      grant_oh_reg  <= '0;
      ready_reg     <= '0;
      beat_reg      <= '0;
      wait_reg      <= '0;
      trunc_reg     <= 1'b0;
      clr_reg       <= 1'b0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
    end else begin
      // Decoding the next state keeps these aligned with the state they mark.
      ready_reg     <= (state_next == ST_ACCUM) ? grant_oh_reg : '0;
      clr_reg       <= (state_next == ST_CLEAR);
      res_valid_reg <= (state_next == ST_RESULT);
      case (state_reg)
        ST_IDLE: begin
          if (arb_any) begin
            grant_id_reg <= arb_id;
            grant_oh_reg <= arb_grant;
          end
        end
        ST_CLEAR: begin
          beat_reg  <= '0;
          wait_reg  <= '0;
          trunc_reg <= 1'b0;
        end
        ST_ACCUM: begin
          if (xfer) begin
            beat_reg <= beat_inc;
            if (!xfer_last && beat_full) trunc_reg <= 1'b1;
          end
        end
        ST_WAIT: begin
          wait_reg <= wait_reg + LAT_W'(1);
          if (wait_done) res_data_reg <= ivG_dp_data;
        end
        ST_RESULT: begin
          if (ib_res_ready) rr_ptr_reg <= grant_id_reg;
        end
        default: ;
      endcase
    end
  end

endmodule
